t05_sram_responder: RTL and testbench
=====================================

Name: t05_sram_responder

Overview:
- Memory-side end of the team 05 SRAM request bus: accepts single-word read/write requests (wr_en, r_en, select, addr, data_i) from the t05 SRAM master and returns busy_o and data_o.
- Backs the shared histogram / Huffman-tree / codebook window at base 0x33000000 with an internal word array.
- Enforces a fixed access latency so the master's busy_o falling-edge handshake behaves the same as it does against the real memory controller.

Parameters:
- BASE_ADDR, 32'h33000000, byte address of word 0.
- DEPTH, 2048, number of 32-bit words backed (power of two).
- LATENCY, 2, cycles busy_o stays high per accepted request (1..15).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset (asserted at 0).
- wr_en  input  1  write request.
- r_en  input  1  read request.
- select  input  4  byte lane enables, bit i = data bits [8i+7:8i].
- addr  input  32  byte address.
- data_i  input  32  write data.
- busy_o  output  1  access in progress.
- data_o  output  32  read data, valid from busy_o falling edge.
- err_o  output  1  one-cycle pulse: last access was out of range or misaligned.

Behaviour:
Reset:
- rst=0 immediately forces state IDLE, busy_o=0, data_o=0, err_o=0, counter=0.
- Array contents are not reset. An access in flight is aborted and its write is not performed.

States: IDLE, ACCESS.

IDLE (busy_o=0):
- On a rising edge with wr_en|r_en=1, latch addr, data_i, select and op, then go to ACCESS with counter=LATENCY-1.
- wr_en and r_en both 1: treated as a write only.

ACCESS (busy_o=1):
- wr_en/r_en are ignored; the request is not queued and the master must re-present it.
- Counter decrements each cycle. On the edge where counter==0, perform the access and return to IDLE.
- busy_o is therefore high for exactly LATENCY cycles and low for at least one cycle between back-to-back accesses.

Access decode:
- off = latched_addr - BASE_ADDR (32-bit unsigned, wraps).
- Valid iff latched_addr >= BASE_ADDR, off[1:0]==0, and off>>2 < DEPTH. idx = off[log2(DEPTH)+1:2].

Completion:
- Valid write: mem[idx] updated per the byte-select rule. data_o unchanged.
- Valid read: data_o <= mem[idx], registered on the same edge busy_o falls, and held until the next completed read.
- Invalid access: no array change. A read sets data_o <= 0. err_o=1 for exactly the first IDLE cycle, otherwise 0.

Write-then-read to the same index returns the new data; there is no bypass hazard because accesses are serialized.

Optional Feature:
T05_SRAM_RESP_BYTE_SEL_EN
- Defined: on a write, only lanes with select[i]=1 are updated. A write with select=4'b0000 is a no-op but still takes LATENCY cycles. Reads ignore select.
- Undefined: select is ignored and every valid write replaces the full word.

Test Plan:
- Reset then write: rst=0 for 3 cycles, release; wr_en=1, addr=0x33000010, data_i=0xDEADBEEF, select=4'hF for one cycle -> busy_o=1 for exactly 2 cycles, then 0; err_o stays 0.
- Read-back: r_en=1, addr=0x33000010 -> busy_o high 2 cycles; data_o=0xDEADBEEF on the falling edge and held while idle.
- Byte lanes (macro defined): write 0x11223344 with select=4'b0101 over 0xDEADBEEF -> read returns 0xDE22BE44. Macro undefined -> returns 0x11223344.
- Out of range / misaligned: write to 0x33000000+DEPTH*4, then read 0x33000002 and 0x32FFFFFC -> err_o pulses once per access; data_o=0 after each read; a later read of 0x33000010 is unchanged.
- Request while busy: issue a write, then a second write to 0x33000020 one cycle later with a different value -> second request ignored; mem at 0x33000020 still holds its prior value. Re-presented after busy_o falls -> accepted.
- Reset mid-access: write 0x0BADF00D to 0x33000030, rst=0 during cycle 1 of ACCESS -> busy_o=0 and data_o=0 immediately; a subsequent read of 0x33000030 does not return 0x0BADF00D (prior value preserved).

Source files
------------

// File: rtl/t05_sram_responder.sv
// Memory-side responder for the team 05 SRAM request bus: fixed-latency single-word access to an internal array.
// Optional macro T05_SRAM_RESP_BYTE_SEL_EN enables per-byte write lanes from select; otherwise writes replace the full word.
module t05_sram_responder #(
  parameter logic [31:0] BASE_ADDR = 32'h33000000,
  parameter int          DEPTH     = 2048,
  parameter int          LATENCY   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic        r_en,
  input  logic [3:0]  select,
  input  logic [31:0] addr,
  input  logic [31:0] data_i,
  output logic        busy_o,
  output logic [31:0] data_o,
  output logic        err_o
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t          state_q, state_d;
  logic [3:0]      cnt_q;
  logic [31:0]     addr_q;
  logic [31:0]     wdata_q;
  logic            write_q;
  logic [3:0]      wmask;
  logic [31:0]     mem [DEPTH];

  logic [31:0]     off;
  logic            addr_ok;
  logic [AW-1:0]   idx;
  logic            start;
  logic            done;

  assign start  = (state_q == IDLE) && (wr_en || r_en);
  assign done   = (state_q == ACCESS) && (cnt_q == 4'd0);
  assign busy_o = (state_q == ACCESS);

  // Offset wraps on addresses below the base, so the explicit >= test rejects them.
  assign off     = addr_q - BASE_ADDR;
  assign addr_ok = (addr_q >= BASE_ADDR) && (off[1:0] == 2'b00) && (off[31:2] < 30'(DEPTH));
  assign idx     = off[AW+1:2];

  // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = ACCESS;
      ACCESS:  if (done)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

`ifdef T05_SRAM_RESP_BYTE_SEL_EN
  logic [3:0] sel_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       sel_q <= 4'h0;
    else if (start) sel_q <= select;
  end

  assign wmask = sel_q;
`else
  logic unused_sel;

  assign unused_sel = ^select;
  assign wmask      = 4'hF;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      write_q <= 1'b0;
      data_o  <= 32'h0;
      err_o   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_o   <= done && !addr_ok;
      if (start) begin
        addr_q  <= addr;
        wdata_q <= data_i;
        write_q <= wr_en;
        cnt_q   <= 4'(LATENCY - 1);
      end else if (state_q == ACCESS && !done) begin
        cnt_q <= cnt_q - 4'd1;
      end
      if (done && !write_q) data_o <= addr_ok ? mem[idx] : 32'h0;
    end
  end

  // NOTE: the array has no reset; a reset simply returns the FSM to IDLE so an in-flight write never lands.
  always_ff @(posedge clk) begin
    if (done && write_q && addr_ok) begin
      for (int i = 0; i < 4; i++) begin
        if (wmask[i]) mem[idx][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_t05_sram_responder.sv
// Scoreboard bench for t05_sram_responder: stimulus pushes expected completions, a negedge monitor checks them.
module tb_t05_sram_responder;

  localparam int LATENCY = 2;

`ifdef T05_SRAM_RESP_BYTE_SEL_EN
  localparam logic [31:0] BL_EXP = 32'hDE22BE44;
`else
  localparam logic [31:0] BL_EXP = 32'h11223344;
`endif

  logic        clk;
  logic        rst;
  logic        wr_en;
  logic        r_en;
  logic [3:0]  select;
  logic [31:0] addr;
  logic [31:0] data_i;
  logic        busy_o;
  logic [31:0] data_o;
  logic        err_o;

  typedef struct {
    string       name;
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_dout = 32'h0;

  t05_sram_responder #(.LATENCY(LATENCY)) dut (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (wr_en),
    .r_en   (r_en),
    .select (select),
    .addr   (addr),
    .data_i (data_i),
    .busy_o (busy_o),
    .data_o (data_o),
    .err_o  (err_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic push_exp(input string name, input bit is_write, input logic [31:0] rd_data,
                          input logic err);
    exp_t e;
    e.name = name;
    e.err  = err;
    if (is_write) e.data = exp_dout;
    else begin
      e.data   = err ? 32'h0 : rd_data;
      exp_dout = e.data;
    end
    sb.push_back(e);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy_o && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (busy_o) check({name, "_timeout"}, 32'(busy_o), 32'h0);
  endtask

  // Presents one request for one cycle (starting 1 time unit after a rising edge) and waits for completion.
  task automatic access(input string name, input bit w, input bit r, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] s, input logic [31:0] rd_exp,
                        input logic err_exp);
    wr_en = w; r_en = r; addr = a; data_i = d; select = s;
    push_exp(name, w, rd_exp, err_exp);
    @(posedge clk); #1;
    wr_en = 1'b0; r_en = 1'b0;
    wait_idle(name);
  endtask

  // Monitor: busy_o falling edge pops one expectation; err_o must be low everywhere else.
  initial begin
    logic prev_busy = 1'b0;
    int   busy_cnt  = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        prev_busy = 1'b0;
        busy_cnt  = 0;
      end else begin
        if (prev_busy && !busy_o) begin
          if (sb.size() == 0) begin
            check("unexpected_completion", 32'h1, 32'h0);
          end else begin
            e = sb.pop_front();
            check({e.name, "_busy_len"}, 32'(busy_cnt), 32'(LATENCY));
            check({e.name, "_data"}, data_o, e.data);
            check({e.name, "_err"}, 32'(err_o), 32'(e.err));
          end
          busy_cnt = 0;
        end else begin
          check("err_idle", 32'(err_o), 32'h0);
        end
        if (busy_o) busy_cnt++;
        prev_busy = busy_o;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    rst = 1'b0; wr_en = 1'b0; r_en = 1'b0; select = 4'h0; addr = 32'h0; data_i = 32'h0;
    #1;
    check("rst_busy", 32'(busy_o), 32'h0);
    check("rst_data", data_o, 32'h0);
    check("rst_err", 32'(err_o), 32'h0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;

    access("wr10", 1, 0, 32'h33000010, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0);
    access("rd10", 0, 1, 32'h33000010, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0);
    repeat (3) @(posedge clk); #1;
    check("rd10_held", data_o, 32'hDEADBEEF);

    access("wr_lanes", 1, 0, 32'h33000010, 32'h11223344, 4'b0101, 32'h0, 1'b0);
    access("rd_lanes", 0, 1, 32'h33000010, 32'h0, 4'h0, BL_EXP, 1'b0);

    access("wr_oor", 1, 0, 32'h33002000, 32'hFFFFFFFF, 4'hF, 32'h0, 1'b1);
    access("rd_misal", 0, 1, 32'h33000002, 32'h0, 4'h0, 32'h0, 1'b1);
    access("rd_below", 0, 1, 32'h32FFFFFC, 32'h0, 4'h0, 32'h0, 1'b1);
    access("rd10_again", 0, 1, 32'h33000010, 32'h0, 4'h0, BL_EXP, 1'b0);

    access("wr_last", 1, 0, 32'h33001FFC, 32'hA5A50001, 4'hF, 32'h0, 1'b0);
    access("rd_last", 0, 1, 32'h33001FFC, 32'h0, 4'h0, 32'hA5A50001, 1'b0);

    access("wr_both", 1, 1, 32'h33000040, 32'h12345678, 4'hF, 32'h0, 1'b0);
    access("rd40", 0, 1, 32'h33000040, 32'h0, 4'h0, 32'h12345678, 1'b0);

    // Second request arrives while busy and must be dropped.
    access("wr20_prior", 1, 0, 32'h33000020, 32'h55AA55AA, 4'hF, 32'h0, 1'b0);
    wr_en = 1'b1; addr = 32'h33000024; data_i = 32'h77777777; select = 4'hF;
    push_exp("wr24", 1, 32'h0, 1'b0);
    @(posedge clk); #1;
    addr = 32'h33000020; data_i = 32'h99999999;
    @(posedge clk); #1;
    wr_en = 1'b0;
    wait_idle("wr24");
    access("rd20_kept", 0, 1, 32'h33000020, 32'h0, 4'h0, 32'h55AA55AA, 1'b0);
    access("wr20_retry", 1, 0, 32'h33000020, 32'h99999999, 4'hF, 32'h0, 1'b0);
    access("rd20_new", 0, 1, 32'h33000020, 32'h0, 4'h0, 32'h99999999, 1'b0);
    access("rd24", 0, 1, 32'h33000024, 32'h0, 4'h0, 32'h77777777, 1'b0);

    // Reset during the first ACCESS cycle aborts the write.
    access("wr30_prior", 1, 0, 32'h33000030, 32'hCAFEF00D, 4'hF, 32'h0, 1'b0);
    wr_en = 1'b1; addr = 32'h33000030; data_i = 32'h0BADF00D; select = 4'hF;
    @(posedge clk); #1;
    wr_en = 1'b0;
    check("abort_busy_before", 32'(busy_o), 32'h1);
    #2 rst = 1'b0;
    #1;
    check("abort_busy", 32'(busy_o), 32'h0);
    check("abort_data", data_o, 32'h0);
    check("abort_err", 32'(err_o), 32'h0);
    exp_dout = 32'h0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    access("rd30_after_abort", 0, 1, 32'h33000030, 32'h0, 4'h0, 32'hCAFEF00D, 1'b0);

    repeat (4) @(posedge clk); #1;
    check("sb_drained", 32'(sb.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
